// File: rtl/riscv_pkg.sv
// Shared RV32 datapath width and ALU operation encoding.
package riscv_pkg;

  parameter int unsigned XLEN = 32;

  typedef enum logic [4:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_SLT,
    ALU_SLTU,
    ALU_MUL,
    ALU_MULH,
    ALU_MULHSU,
    ALU_MULHU,
    ALU_DIV,
    ALU_DIVU,
    ALU_REM,
    ALU_REMU
  } alu_op_e;

endpackage

// File: rtl/ex_muldiv_issue.sv
// Execute-stage initiator for the ALU handshake. It latches one ID/EX op and
// holds the operands on the ALU until the result is known. Single-cycle ops
// complete in ISSUE. Divide/remainder ops wait for alu_ready, or for a timeout
// that forces an all-ones result flagged with out_err. The result is then
// captured into an EX/MEM register that has valid/ready backpressure.
module ex_muldiv_issue
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN           = riscv_pkg::XLEN,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 7
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  alu_op_e         in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [4:0]      in_rd,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output alu_op_e         alu_op,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero,
  input  logic            alu_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_zero,
  output logic [4:0]      out_rd,
  output logic            out_err,
  output logic            ex_stall,
  output logic            busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  localparam logic [CNT_W-1:0] CountLast = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e          state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d;
  alu_op_e         op_q, op_d;
  logic [4:0]      rd_q, rd_d;

  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_result_q, out_result_d;
  logic            out_zero_q, out_zero_d;
  logic [4:0]      out_rd_q, out_rd_d;
  logic            out_err_q, out_err_d;

  logic            accept;
  logic            capture;
  logic [XLEN-1:0] cap_result;
  logic            cap_zero;
  logic            cap_err;

  function automatic logic is_multi(alu_op_e op);
    return op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  endfunction

  // The output register is empty or draining whenever IDLE accepts, so a
  // capture never overwrites an unconsumed result.
  assign in_ready = (state_q == StIdle) & (~out_valid_q | out_ready) & ~flush;
  assign accept   = in_valid & in_ready;
  assign ex_stall = in_valid & ~in_ready;
  assign busy     = (state_q != StIdle);

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_op     = op_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_zero   = out_zero_q;
  assign out_rd     = out_rd_q;
  assign out_err    = out_err_q;

  // Next-state: issue sequencing, timeout, capture and flush.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    rd_d         = rd_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_zero_d   = out_zero_q;
    out_rd_d     = out_rd_q;
    out_err_d    = out_err_q;
    capture      = 1'b0;
    cap_result   = alu_result;
    cap_zero     = alu_zero;
    cap_err      = 1'b0;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          a_d     = in_a;
          b_d     = in_b;
          op_d    = in_op;
          rd_d    = in_rd;
          state_d = StIssue;
        end
      end
      StIssue: begin
        // alu_ready may still be stale from an earlier divide, so it is not
        // trusted until the first WAIT cycle.
        if (is_multi(op_q)) begin
          state_d = StWait;
          count_d = '0;
        end else begin
          capture = 1'b1;
        end
      end
      StWait: begin
        if (alu_ready) begin
          capture = 1'b1;
        end else if (count_q == CountLast) begin
          capture    = 1'b1;
          cap_result = '1;
          cap_zero   = 1'b0;
          cap_err    = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (capture && !flush) begin
      out_valid_d  = 1'b1;
      out_result_d = cap_result;
      out_zero_d   = cap_zero;
      out_rd_d     = rd_q;
      out_err_d    = cap_err;
      state_d      = StIdle;
      a_d          = '0;
      b_d          = '0;
      op_d         = ALU_ADD;
      count_d      = '0;
    end

    // The idle op keeps the divider from restarting on stale operands.
    if (flush) begin
      state_d     = StIdle;
      a_d         = '0;
      b_d         = '0;
      op_d        = ALU_ADD;
      count_d     = '0;
      out_valid_d = 1'b0;
    end
  end

  // State, ALU operand and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      count_q      <= '0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= ALU_ADD;
      rd_q         <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_zero_q   <= 1'b0;
      out_rd_q     <= '0;
      out_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      rd_q         <= rd_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_zero_q   <= out_zero_d;
      out_rd_q     <= out_rd_d;
      out_err_q    <= out_err_d;
    end
  end

endmodule
